mem_port_arbiter: RTL and testbench

//  Shares the single unified memory port of the multi-cycle RISC-V between two masters.
//  M0 is the core load/store/fetch port. M1 is the boot-loader/DMA port.

---
 rtl/mem_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin share of one memory port between M0 (core) and M1 (boot/DMA).
// Latency: mem_en 1 cycle after req in IDLE; done 1 cycle after mem_ready or after TMO_CYC busy cycles.
// Backpressure: masters hold req until done; the slave stalls with mem_ready, bounded by a watchdog.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TMO_CYC = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req,
  input  logic [1:0]          we,
  input  logic [2*ADDR_W-1:0] addr,
  input  logic [2*DATA_W-1:0] wdata,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          done,
  output logic [1:0]          err,
  output logic [1:0]          gnt,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready
);

  localparam int               CNT_W    = $clog2(TMO_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TMO_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             last_gnt_q;   // index of the previous owner
  logic [CNT_W-1:0] cnt_q;        // busy cycles spent waiting on the slave

  logic [1:0] eligible;
  logic       any_req;
  logic       win;
  logic       cnt_last;
  logic       do_grant;
  logic       do_ok;
  logic       do_tmo;
  logic       do_inc;
  logic       do_release;

  // Arbitration: a master whose done is still high is not considered; on a tie the
  // master that did not own the port last time wins.
  always_comb begin
    eligible = req & ~done;
    any_req  = |eligible;
    if (eligible == 2'b11) begin
      win = ~last_gnt_q;
    end else begin
      win = eligible[1];
    end
    cnt_last = (cnt_q == CNT_LAST);
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: BUSY ends on ready or on the last watchdog count; RESP lasts one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (any_req) state_d = S_BUSY;
      S_BUSY:  if (mem_ready || cnt_last) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode: one-cycle action strobes for the datapath; ready beats the timeout.
  always_comb begin
    do_grant   = 1'b0;
    do_ok      = 1'b0;
    do_tmo     = 1'b0;
    do_inc     = 1'b0;
    do_release = 1'b0;
    case (state_q)
      S_IDLE: do_grant = any_req;
      S_BUSY: begin
        do_ok  = mem_ready;
        do_tmo = !mem_ready && cnt_last;
        do_inc = !mem_ready && !cnt_last;
      end
      S_RESP:  do_release = 1'b1;
      default: ;
    endcase
  end

  // Datapath: latch the winner's request, hold it stable for the slave, report completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_gnt_q <= 1'b1;
      cnt_q      <= '0;
      gnt        <= 2'b00;
      done       <= 2'b00;
      err        <= 2'b00;
      rdata      <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      done <= 2'b00;
      err  <= 2'b00;
      if (do_grant) begin
        gnt        <= win ? 2'b10 : 2'b01;
        last_gnt_q <= win;
        cnt_q      <= '0;
        mem_en     <= 1'b1;
        mem_we     <= we[win];
        mem_addr   <= win ? addr[2*ADDR_W-1:ADDR_W]  : addr[ADDR_W-1:0];
        mem_wdata  <= win ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];
      end
      if (do_ok) begin
        if (!mem_we) rdata <= mem_rdata;
        done   <= gnt;
        mem_en <= 1'b0;
      end
      if (do_tmo) begin
        rdata  <= '0;
        done   <= gnt;
        err    <= gnt;
        mem_en <= 1'b0;
      end
      if (do_inc && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (do_release) begin
        gnt <= 2'b00;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations, then random
// traffic, all compared every cycle against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TMO_CYC = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  req;
  logic [1:0]  we;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [31:0] rdata;
  logic [1:0]  done;
  logic [1:0]  err;
  logic [1:0]  gnt;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  int checks   = 0;
  int failures = 0;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TMO_CYC(TMO_CYC)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .done(done), .err(err), .gnt(gnt), .mem_en(mem_en),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- slave model (stimulus side) ----------------
  bit          slave_rand  = 1'b0;
  int          ready_pct   = 50;
  int          ready_after = 0;
  logic [31:0] rd_val      = 32'h0;
  int          en_cnt      = 0;

  initial begin
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (slave_rand) begin
        mem_rdata = $urandom;
        mem_ready = ($urandom_range(99, 0) < ready_pct);
      end else begin
        mem_rdata = rd_val;
        mem_ready = mem_en && (en_cnt == ready_after);
      end
      en_cnt = mem_en ? en_cnt + 1 : 0;
    end
  end

  // ---------------- reference model ----------------
  // A transaction is either absent (owner=-1), in flight (owner set, not finished), or
  // in its single report cycle (finished). Expectations are derived from that view.
  int          m_owner = -1;
  bit          m_fin   = 1'b0;
  logic        m_last  = 1'b1;
  int          m_wait  = 0;
  int          m_w     = -1;
  logic [1:0]  e_done  = 2'b00;
  logic [1:0]  e_err   = 2'b00;
  logic [31:0] e_rdata = 32'h0;
  logic [31:0] e_addr  = 32'h0;
  logic [31:0] e_wdata = 32'h0;
  logic        e_we    = 1'b0;

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_owner = -1; m_fin = 1'b0; m_last = 1'b1; m_wait = 0;
        e_done = 2'b00; e_err = 2'b00; e_rdata = 32'h0;
        e_addr = 32'h0; e_wdata = 32'h0; e_we = 1'b0;
      end else if (m_fin) begin
        m_owner = -1; m_fin = 1'b0; e_done = 2'b00; e_err = 2'b00;
      end else if (m_owner < 0) begin
        m_w = -1;
        if (req == 2'b11)  m_w = (m_last == 1'b0) ? 1 : 0;
        else if (req[0])   m_w = 0;
        else if (req[1])   m_w = 1;
        if (m_w >= 0) begin
          m_owner = m_w;
          m_last  = (m_w == 1);
          m_wait  = 0;
          e_we    = we[m_w];
          e_addr  = addr[m_w*32 +: 32];
          e_wdata = wdata[m_w*32 +: 32];
        end
      end else begin
        if (mem_ready) begin
          if (!e_we) e_rdata = mem_rdata;
          e_done[m_owner] = 1'b1;
          m_fin = 1'b1;
        end else if (m_wait == TMO_CYC - 1) begin
          e_done[m_owner] = 1'b1;
          e_err[m_owner]  = 1'b1;
          e_rdata = 32'h0;
          m_fin = 1'b1;
        end else begin
          m_wait++;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [1:0] eg;
  logic       een;
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        eg  = (m_owner < 0) ? 2'b00 : ((m_owner == 0) ? 2'b01 : 2'b10);
        een = (m_owner >= 0) && !m_fin;
        chk("gnt",    64'(gnt),    64'(eg));
        chk("mem_en", 64'(mem_en), 64'(een));
        chk("done",   64'(done),   64'(e_done));
        chk("err",    64'(err),    64'(e_err));
        chk("rdata",  64'(rdata),  64'(e_rdata));
        if (een) begin
          chk("mem_we",    64'(mem_we),    64'(e_we));
          chk("mem_addr",  64'(mem_addr),  64'(e_addr));
          chk("mem_wdata", 64'(mem_wdata), 64'(e_wdata));
        end
        chk("inv_gnt_onehot0",  64'($onehot0(gnt)),  64'(1));
        chk("inv_done_onehot0", 64'($onehot0(done)), 64'(1));
        chk("inv_done_in_gnt",  64'(done & ~gnt),    64'(0));
        chk("inv_err_in_gnt",   64'(err & ~gnt),     64'(0));
      end
    end
  end

  // ---------------- directed transaction helper ----------------
  int          r_en, r_first;
  logic [1:0]  r_dn, r_er, r_gnt;
  logic        r_we;
  logic [31:0] r_addr, r_wdata;

  task automatic do_txn(input int m, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input int rdy, input logic [31:0] rv);
    ready_after = rdy;
    rd_val      = rv;
    we[m]              = w;
    addr[m*32 +: 32]   = a;
    wdata[m*32 +: 32]  = d;
    req[m]             = 1'b1;
    r_en = 0; r_first = -1; r_dn = 2'b00; r_er = 2'b00;
    r_gnt = 2'b00; r_we = 1'b0; r_addr = 32'h0; r_wdata = 32'h0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (mem_en) begin
        if (r_first < 0) begin
          r_first = i; r_gnt = gnt; r_we = mem_we; r_addr = mem_addr; r_wdata = mem_wdata;
        end
        r_en++;
      end
      if (done != 2'b00) begin
        r_dn = done; r_er = err;
        break;
      end
    end
    req[m] = 1'b0;
  endtask

  int order [4];
  int n_done;
  int pcts [6] = '{50, 12, 0, 100, 30, 5};

  initial begin
    req = 2'b00; we = 2'b00; addr = 64'h0; wdata = 64'h0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_gnt",       64'(gnt),       64'(0));
    chk("rst_mem_en",    64'(mem_en),    64'(0));
    chk("rst_mem_we",    64'(mem_we),    64'(0));
    chk("rst_mem_addr",  64'(mem_addr),  64'(0));
    chk("rst_mem_wdata", 64'(mem_wdata), 64'(0));
    chk("rst_rdata",     64'(rdata),     64'(0));
    chk("rst_done",      64'(done),      64'(0));
    chk("rst_err",       64'(err),       64'(0));
    rst = 1'b1;
    @(negedge clk);

    // T1: single load with two wait states
    do_txn(0, 1'b0, 32'h1000, 32'h0, 2, 32'hDEADBEEF);
    chk("t1_req_to_en",  64'(r_first), 64'(0));
    chk("t1_en_cycles",  64'(r_en),    64'(3));
    chk("t1_mem_addr",   64'(r_addr),  64'(32'h1000));
    chk("t1_done",       64'(r_dn),    64'(2'b01));
    chk("t1_err",        64'(r_er),    64'(2'b00));
    chk("t1_rdata",      64'(rdata),   64'(32'hDEADBEEF));
    @(negedge clk);

    // T2: tie from reset, both held -> 0,1,0,1
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    ready_after = 0; rd_val = 32'h12345678;
    we = 2'b00; addr = {32'h0000_5004, 32'h0000_5000};
    req = 2'b11;
    n_done = 0;
    for (int i = 0; i < 80 && n_done < 4; i++) begin
      @(negedge clk);
      if (done != 2'b00) begin
        order[n_done] = done[1] ? 1 : 0;
        n_done++;
      end
    end
    req = 2'b00;
    chk("t2_count", 64'(n_done), 64'(4));
    chk("t2_order0", 64'(order[0]), 64'(0));
    chk("t2_order1", 64'(order[1]), 64'(1));
    chk("t2_order2", 64'(order[2]), 64'(0));
    chk("t2_order3", 64'(order[3]), 64'(1));
    @(negedge clk);

    // T3: store passthrough from M1, immediate ready; rdata keeps the last load
    do_txn(1, 1'b1, 32'h2004, 32'h0000_00A5, 0, 32'h0BAD0BAD);
    chk("t3_gnt",       64'(r_gnt),   64'(2'b10));
    chk("t3_mem_we",    64'(r_we),    64'(1));
    chk("t3_mem_addr",  64'(r_addr),  64'(32'h2004));
    chk("t3_mem_wdata", 64'(r_wdata), 64'(32'hA5));
    chk("t3_done",      64'(r_dn),    64'(2'b10));
    chk("t3_err",       64'(r_er),    64'(2'b00));
    chk("t3_rdata",     64'(rdata),   64'(32'h12345678));
    @(negedge clk);

    // T4: timeout, then M1 serviced normally
    do_txn(0, 1'b0, 32'h3000, 32'h0, 99, 32'h77777777);
    chk("t4_en_cycles", 64'(r_en),  64'(TMO_CYC));
    chk("t4_done",      64'(r_dn),  64'(2'b01));
    chk("t4_err",       64'(r_er),  64'(2'b01));
    chk("t4_rdata",     64'(rdata), 64'(0));
    @(negedge clk);
    do_txn(1, 1'b0, 32'h3004, 32'h0, 1, 32'hCAFEF00D);
    chk("t4b_en_cycles", 64'(r_en),  64'(2));
    chk("t4b_done",      64'(r_dn),  64'(2'b10));
    chk("t4b_err",       64'(r_er),  64'(2'b00));
    chk("t4b_rdata",     64'(rdata), 64'(32'hCAFEF00D));
    @(negedge clk);

    // T5: ready on the final watchdog count wins
    do_txn(0, 1'b0, 32'h4000, 32'h0, TMO_CYC - 1, 32'h5A5A1234);
    chk("t5_en_cycles", 64'(r_en),  64'(TMO_CYC));
    chk("t5_done",      64'(r_dn),  64'(2'b01));
    chk("t5_err",       64'(r_er),  64'(2'b00));
    chk("t5_rdata",     64'(rdata), 64'(32'h5A5A1234));
    @(negedge clk);

    // T6: reset while busy, then re-grant of the still-pending M0
    ready_after = 99;
    we[0] = 1'b0; addr[31:0] = 32'h6000; req[0] = 1'b1;
    repeat (4) @(negedge clk);
    chk("t6_busy", 64'(mem_en), 64'(1));
    rst = 1'b0;
    #1;
    chk("t6_rst_mem_en", 64'(mem_en), 64'(0));
    chk("t6_rst_gnt",    64'(gnt),    64'(0));
    chk("t6_rst_rdata",  64'(rdata),  64'(0));
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("t6_no_done", 64'(done), 64'(0));
    end
    rst = 1'b1;
    do_txn(0, 1'b0, 32'h6000, 32'h0, 1, 32'h600D600D);
    chk("t6_regrant_first", 64'(r_first), 64'(0));
    chk("t6_regrant_gnt",   64'(r_gnt),   64'(2'b01));
    chk("t6_done",          64'(r_dn),    64'(2'b01));
    chk("t6_rdata",         64'(rdata),   64'(32'h600D600D));
    @(negedge clk);

    // Random traffic, model compare runs every cycle
    slave_rand = 1'b1;
    for (int cyc = 0; cyc < 1200; cyc++) begin
      @(negedge clk);
      ready_pct = pcts[(cyc / 200) % 6];
      for (int m = 0; m < 2; m++) begin
        if (req[m]) begin
          if ($urandom_range(9, 0) == 0) req[m] = 1'b0;
        end else if ($urandom_range(9, 0) < 3) begin
          req[m] = 1'b1;
        end
        if ($urandom_range(3, 0) == 0) begin
          we[m]             = $urandom_range(1, 0) == 1;
          addr[m*32 +: 32]  = $urandom;
          wdata[m*32 +: 32] = $urandom;
        end
      end
      if (cyc == 600) rst = 1'b0;
      if (cyc == 602) rst = 1'b1;
    end
    slave_rand = 1'b0;
    req = 2'b00;
    repeat (TMO_CYC + 4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
